// File: rtl/spi_debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_debug_pkg
//  Description : Shared definitions for the SPI debug bridge: command opcodes,
//                FSM state encoding, readback source encoding and the bit
//                positions of the sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_debug_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR       = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_WAIT  = 2'd3
    } state_t;

    // Readback source driving o_spi_data
    typedef enum logic [1:0] {
        SRC_CH   = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_NONE = 2'd2
    } src_t;

    // Command opcodes (top nibble of the command word); 8..15 are illegal
    localparam logic [3:0] c_op_nop      = 4'd0;
    localparam logic [3:0] c_op_set_addr = 4'd1;
    localparam logic [3:0] c_op_wr_lo    = 4'd2;
    localparam logic [3:0] c_op_wr_hi    = 4'd3;
    localparam logic [3:0] c_op_commit   = 4'd4;
    localparam logic [3:0] c_op_rd_mem   = 4'd5;
    localparam logic [3:0] c_op_sel_ch   = 4'd6;
    localparam logic [3:0] c_op_clr_err  = 4'd7;

    // Sticky error bit indices
    localparam int c_err_illegal = 0;
    localparam int c_err_wr_idle = 1;
    localparam int c_err_overrun = 2;

endpackage
`default_nettype wire

// File: rtl/spi_probe_mux.sv
`default_nettype none
// ============================================================================
//  Module      : spi_probe_mux
//  Description : Registered readback selector. Picks one of N_CH probe
//                channels, the memory read buffer, or zero, and registers it.
//                A channel index at or beyond N_CH reads as zero.
//  Ports       : i_clk, i_rst   - clock, synchronous active-high reset
//                i_src          - source select (spi_debug_pkg::src_t encoding)
//                i_ch           - probe channel index
//                i_probe        - flat probe bus, channel k at [k*NB_BITS +: NB_BITS]
//                i_mem          - memory readback value
//                o_data         - registered selected value
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_probe_mux
    import spi_debug_pkg::*;
#(
    parameter int NB_BITS = 32,
    parameter int N_CH    = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [1:0]                i_src,
    input  logic [3:0]                i_ch,
    input  logic [N_CH*NB_BITS-1:0]   i_probe,
    input  logic [NB_BITS-1:0]        i_mem,
    output logic [NB_BITS-1:0]        o_data
);

    logic [NB_BITS-1:0] w_ch_data [N_CH];
    logic [NB_BITS-1:0] w_sel;
    logic [NB_BITS-1:0] r_data;

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign w_ch_data[k] = i_probe[k*NB_BITS +: NB_BITS];
    end

    // Indices with no matching channel fall through to the zero default
    always_comb begin
        w_sel = '0;
        if (i_src == SRC_MEM) begin
            w_sel = i_mem;
        end else if (i_src == SRC_CH) begin
            for (int k = 0; k < N_CH; k++) begin
                if (i_ch == 4'(k)) begin
                    w_sel = w_ch_data[k];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= '0;
        end else begin
            r_data <= w_sel;
        end
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/spi_debug_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_debug_bridge
//  Description : Command-driven bridge between the SPI slave and the
//                instruction RAM port, with a readback mux over N_CH debug
//                probe channels and sticky error reporting.
//  Ports       : i_clk, i_rst     - clock, synchronous active-high reset
//                i_spi_cmd/valid  - command word and its one-cycle strobe
//                i_in_use         - debug mode active (gates RAM writes)
//                i_probe          - flat probe bus
//                i_ram_rdata      - RAM read data (1 cycle after o_ram_en)
//                o_ram_addr/wdata/we/en - RAM port
//                o_spi_data       - registered readback to SPI slave
//                o_busy           - FSM not idle
//                o_err            - sticky errors {overrun, wr_idle, illegal}
//  Config      : SPI_BRIDGE_AUTOINC_EN - when defined, the address advances by
//                one (wrapping) on leaving WR and RD_WAIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_debug_bridge
    import spi_debug_pkg::*;
#(
    parameter int NB_BITS   = 32,
    parameter int RAM_DEPTH = 10,
    parameter int N_CH      = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NB_BITS-1:0]        i_spi_cmd,
    input  logic                      i_spi_valid,
    input  logic                      i_in_use,
    input  logic [N_CH*NB_BITS-1:0]   i_probe,
    input  logic [NB_BITS-1:0]        i_ram_rdata,
    output logic [RAM_DEPTH-1:0]      o_ram_addr,
    output logic [NB_BITS-1:0]        o_ram_wdata,
    output logic                      o_ram_we,
    output logic                      o_ram_en,
    output logic [NB_BITS-1:0]        o_spi_data,
    output logic                      o_busy,
    output logic [2:0]                o_err
);

    localparam logic [4:0]           c_n_ch     = 5'(N_CH);
    localparam logic [RAM_DEPTH-1:0] c_addr_one = {{(RAM_DEPTH-1){1'b0}}, 1'b1};

    state_t               r_state, w_state_nxt;
    src_t                 r_src, w_src_nxt;
    logic [3:0]           r_ch, w_ch_nxt;
    logic [RAM_DEPTH-1:0] r_addr, w_addr_nxt;
    logic [NB_BITS-1:0]   r_wdata, w_wdata_nxt;
    logic [NB_BITS-1:0]   r_rd_buf, w_rd_buf_nxt;
    logic [2:0]           r_err, w_err_set;
    logic                 w_err_clr;
    logic                 w_ram_we, w_ram_en;

    logic [3:0]           w_opcode;
    logic [3:0]           w_cmd_ch;
    logic                 w_unused;

    assign w_opcode = i_spi_cmd[NB_BITS-1:NB_BITS-4];
    assign w_cmd_ch = i_spi_cmd[3:0];
    // Payload bits between the used fields are don't-care
    assign w_unused = ^i_spi_cmd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_src_nxt    = r_src;
        w_ch_nxt     = r_ch;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_rd_buf_nxt = r_rd_buf;
        w_err_set    = '0;
        w_err_clr    = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_en     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_spi_valid) begin
                    case (w_opcode)
                        c_op_nop:      ;
                        c_op_set_addr: w_addr_nxt = i_spi_cmd[RAM_DEPTH-1:0];
                        c_op_wr_lo:    w_wdata_nxt[15:0] = i_spi_cmd[15:0];
                        c_op_wr_hi:    w_wdata_nxt[NB_BITS-1:16] = i_spi_cmd[NB_BITS-17:0];
                        c_op_commit: begin
                            if (i_in_use) begin
                                w_state_nxt = ST_WR;
                            end else begin
                                w_err_set[c_err_wr_idle] = 1'b1;
                            end
                        end
                        c_op_rd_mem:   w_state_nxt = ST_RD_ISSUE;
                        c_op_sel_ch: begin
                            if ({1'b0, w_cmd_ch} >= c_n_ch) begin
                                w_err_set[c_err_illegal] = 1'b1;
                                w_src_nxt = SRC_NONE;
                            end else begin
                                w_src_nxt = SRC_CH;
                                w_ch_nxt  = w_cmd_ch;
                            end
                        end
                        c_op_clr_err:  w_err_clr = 1'b1;
                        default:       w_err_set[c_err_illegal] = 1'b1;
                    endcase
                end
            end
            ST_WR: begin
                // Debug mode may drop during the write cycle; the write is
                // then squashed and flagged.
                w_ram_we = i_in_use;
                if (!i_in_use) begin
                    w_err_set[c_err_wr_idle] = 1'b1;
                end
                w_state_nxt = ST_IDLE;
`ifdef SPI_BRIDGE_AUTOINC_EN
                w_addr_nxt = r_addr + c_addr_one;
`endif
            end
            ST_RD_ISSUE: begin
                w_ram_en    = 1'b1;
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_rd_buf_nxt = i_ram_rdata;
                w_src_nxt    = SRC_MEM;
                w_state_nxt  = ST_IDLE;
`ifdef SPI_BRIDGE_AUTOINC_EN
                w_addr_nxt = r_addr + c_addr_one;
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Strobes arriving while busy are dropped and flagged
        if (i_spi_valid && (r_state != ST_IDLE)) begin
            w_err_set[c_err_overrun] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_src    <= SRC_CH;
            r_ch     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd_buf <= '0;
            r_err    <= '0;
        end else begin
            r_src    <= w_src_nxt;
            r_ch     <= w_ch_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_rd_buf <= w_rd_buf_nxt;
            r_err    <= w_err_clr ? 3'b000 : (r_err | w_err_set);
        end
    end

    // The mux is fed next-cycle selection so a new source (and the RAM data
    // captured in RD_WAIT) reaches o_spi_data on the same edge it is latched.
    spi_probe_mux #(
        .NB_BITS (NB_BITS),
        .N_CH    (N_CH)
    ) u_probe_mux (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_src   (w_src_nxt),
        .i_ch    (w_ch_nxt),
        .i_probe (i_probe),
        .i_mem   (w_rd_buf_nxt),
        .o_data  (o_spi_data)
    );

    assign o_ram_addr  = r_addr;
    assign o_ram_wdata = r_wdata;
    assign o_ram_we    = w_ram_we;
    assign o_ram_en    = w_ram_en;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_debug_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_debug_bridge
//  Description : Self-checking bench for spi_debug_bridge with a behavioural
//                single-port RAM, a write scoreboard and a probe-select table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_debug_bridge;

    localparam int NB_BITS   = 32;
    localparam int RAM_DEPTH = 10;
    localparam int N_CH      = 4;

    localparam logic [3:0] OP_NOP  = 4'd0, OP_SET = 4'd1, OP_WLO = 4'd2, OP_WHI = 4'd3;
    localparam logic [3:0] OP_COM  = 4'd4, OP_RD  = 4'd5, OP_SEL = 4'd6, OP_CLR = 4'd7;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NB_BITS-1:0]      spi_cmd;
    logic                    spi_valid;
    logic                    in_use;
    logic [N_CH*NB_BITS-1:0] probe;
    logic [NB_BITS-1:0]      ram_rdata;
    logic [RAM_DEPTH-1:0]    ram_addr;
    logic [NB_BITS-1:0]      ram_wdata;
    logic                    ram_we, ram_en;
    logic [NB_BITS-1:0]      spi_data;
    logic                    busy;
    logic [2:0]              err;

    int checks = 0;
    int fails  = 0;

    logic [NB_BITS-1:0] mem [1 << RAM_DEPTH];
    logic [RAM_DEPTH+NB_BITS-1:0] wr_q [$];

    logic [NB_BITS-1:0] pv [N_CH];

    typedef struct {
        logic [3:0]  ch;
        logic [31:0] exp_data;
        logic        exp_err0;
    } sel_vec_t;
    sel_vec_t vecs [6];

    always #5 clk = ~clk;

    spi_debug_bridge #(
        .NB_BITS   (NB_BITS),
        .RAM_DEPTH (RAM_DEPTH),
        .N_CH      (N_CH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_spi_cmd   (spi_cmd),
        .i_spi_valid (spi_valid),
        .i_in_use    (in_use),
        .i_probe     (probe),
        .i_ram_rdata (ram_rdata),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .o_ram_we    (ram_we),
        .o_ram_en    (ram_en),
        .o_spi_data  (spi_data),
        .o_busy      (busy),
        .o_err       (err)
    );

    // Behavioural RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en) ram_rdata <= mem[ram_addr];
    end

    // Write scoreboard: every observed write must match the next expected one
    always @(negedge clk) begin
        if (!rst && ram_we) begin
            checks++;
            if (wr_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", ram_addr, ram_wdata);
            end else begin
                logic [RAM_DEPTH+NB_BITS-1:0] e;
                e = wr_q.pop_front();
                if ({ram_addr, ram_wdata} !== e) begin
                    fails++;
                    $display("FAIL write_sb: got %h/%h required %h/%h",
                             ram_addr, ram_wdata, e[RAM_DEPTH+NB_BITS-1:NB_BITS], e[NB_BITS-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [27:0] pl);
        spi_cmd   = {op, pl};
        spi_valid = 1'b1;
        tick();
        spi_valid = 1'b0;
        spi_cmd   = '0;
    endtask

    task automatic set_probes();
        probe = {pv[3], pv[2], pv[1], pv[0]};
    endtask

    initial begin
        logic [RAM_DEPTH-1:0] exp_addr;

        for (int i = 0; i < (1 << RAM_DEPTH); i++) mem[i] = '0;
        ram_rdata = '0;
        pv[0] = 32'h0BAD_F00D; pv[1] = 32'hCAFE_0001;
        pv[2] = 32'h1234_5678; pv[3] = 32'h8000_0003;
        set_probes();

        vecs[0] = '{4'd0,  32'h0BAD_F00D, 1'b0};
        vecs[1] = '{4'd1,  32'hCAFE_0001, 1'b0};
        vecs[2] = '{4'd2,  32'h1234_5678, 1'b0};
        vecs[3] = '{4'd3,  32'h8000_0003, 1'b0};
        vecs[4] = '{4'd5,  32'h0000_0000, 1'b1};
        vecs[5] = '{4'd15, 32'h0000_0000, 1'b1};

        rst = 1'b1; spi_cmd = '0; spi_valid = 1'b0; in_use = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_spi_data", spi_data, 32'h0);
        check("rst_busy",     {31'b0, busy}, 32'h0);
        check("rst_err",      {29'b0, err}, 32'h0);
        check("rst_addr",     {22'b0, ram_addr}, 32'h0);
        check("rst_we_en",    {30'b0, ram_we, ram_en}, 32'h0);
        check("rst_wdata",    ram_wdata, 32'h0);
        rst = 1'b0;
        tick();
        check("default_ch0", spi_data, pv[0]);

        // Write 0xDEADBEEF to address 5
        send(OP_SET, 28'h005);
        send(OP_WLO, 28'hBEEF);
        send(OP_WHI, 28'hDEAD);
        wr_q.push_back({10'h005, 32'hDEAD_BEEF});
        send(OP_COM, 28'h0);
        check("wr_we",    {31'b0, ram_we}, 32'h1);
        check("wr_addr",  {22'b0, ram_addr}, 32'h005);
        check("wr_wdata", ram_wdata, 32'hDEAD_BEEF);
        check("wr_busy",  {31'b0, busy}, 32'h1);
        tick();
`ifdef SPI_BRIDGE_AUTOINC_EN
        exp_addr = 10'h006;
`else
        exp_addr = 10'h005;
`endif
        check("wr_addr_after", {22'b0, ram_addr}, {22'b0, exp_addr});
        check("wr_busy_after", {31'b0, busy}, 32'h0);

        // Readback: data visible 3 cycles after the strobe, busy for 2
        send(OP_SET, 28'h005);
        send(OP_RD, 28'h0);
        check("rd_busy1", {31'b0, busy}, 32'h1);
        check("rd_en",    {31'b0, ram_en}, 32'h1);
        tick();
        check("rd_busy2", {31'b0, busy}, 32'h1);
        check("rd_en_off", {31'b0, ram_en}, 32'h0);
        tick();
        check("rd_data",  spi_data, 32'hDEAD_BEEF);
        check("rd_busy3", {31'b0, busy}, 32'h0);
        tick();
        check("rd_data_hold", spi_data, 32'hDEAD_BEEF);

        // COMMIT outside debug mode
        in_use = 1'b0;
        send(OP_COM, 28'h0);
        check("idle_commit_we", {31'b0, ram_we}, 32'h0);
        check("idle_commit_busy", {31'b0, busy}, 32'h0);
        check("idle_commit_err", {29'b0, err}, 32'h2);
        send(OP_CLR, 28'h0);
        check("clr_err", {29'b0, err}, 32'h0);

        // Debug mode dropping during the write cycle squashes the write
        in_use = 1'b1;
        send(OP_COM, 28'h0);
        in_use = 1'b0;
        #1;
        check("drop_we", {31'b0, ram_we}, 32'h0);
        tick();
        check("drop_err", {29'b0, err}, 32'h2);
        in_use = 1'b1;
        send(OP_CLR, 28'h0);

        // Address wrap
        send(OP_SET, 28'h3FF);
        wr_q.push_back({10'h3FF, 32'hDEAD_BEEF});
        send(OP_COM, 28'h0);
        check("wrap_wr_addr", {22'b0, ram_addr}, 32'h3FF);
        tick();
`ifdef SPI_BRIDGE_AUTOINC_EN
        exp_addr = 10'h000;
`else
        exp_addr = 10'h3FF;
`endif
        check("wrap_addr", {22'b0, ram_addr}, {22'b0, exp_addr});

        // Probe select table
        for (int i = 0; i < 6; i++) begin
            send(OP_SEL, {24'h0, vecs[i].ch});
            check($sformatf("sel_data_%0d", vecs[i].ch), spi_data, vecs[i].exp_data);
            check($sformatf("sel_err0_%0d", vecs[i].ch), {31'b0, err[0]}, {31'b0, vecs[i].exp_err0});
            send(OP_CLR, 28'h0);
        end

        // Probe tracking is live
        send(OP_SEL, 28'h2);
        pv[2] = 32'h5555_AAAA;
        set_probes();
        tick();
        check("probe_live", spi_data, 32'h5555_AAAA);

        // Overrun: second strobe during a read is dropped
        send(OP_SET, 28'h005);
        send(OP_RD, 28'h0);
        send(OP_SEL, 28'h1);
        tick();
        check("overrun_data", spi_data, 32'hDEAD_BEEF);
        check("overrun_err", {29'b0, err}, 32'h4);
        send(OP_CLR, 28'h0);

        // Illegal opcode
        send(4'hF, 28'h0);
        check("illegal_err", {29'b0, err}, 32'h1);
        check("illegal_busy", {31'b0, busy}, 32'h0);

        // Reset while in RD_ISSUE
        send(OP_SET, 28'h007);
        send(OP_RD, 28'h0);
        check("pre_rst_busy", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_data", spi_data, 32'h0);
        check("mid_rst_addr", {22'b0, ram_addr}, 32'h0);
        check("mid_rst_err",  {29'b0, err}, 32'h0);
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_busy", {31'b0, busy}, 32'h0);
        check("post_rst_ch0", spi_data, pv[0]);

        check("sb_drained", wr_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
